// File: rtl/bus_pkg.sv
// Shared definitions for the bus transfer controller.
//   - Default address/data widths.
//   - Controller state encoding (localparams plus the state enum built on them).
//   - Target codes decoded from the select address bit.
//   - Width of the ACCESS wait-state down-counter.
package bus_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETUP  = SETUP,
    ST_ACCESS = ACCESS,
    ST_DONE   = DONE
  } state_e;

  localparam logic TGT_MEM = 1'b0;
  localparam logic TGT_REG = 1'b1;

  // Holds WAIT_CYCLES in the range 0..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/bus_xfer_ctrl_rr_arb2.sv
// Two-way round-robin picker.
//   CLK, RSTn : clock and synchronous active-low reset
//   req_i     : request vector, bit n from requester n
//   gnt_en_i  : commit the current pick and advance the pointer
//   gnt_c_o   : one-hot grant, combinational from req_i and the pointer
//   last_q_o  : registered index of the most recently granted port (1 after reset)
module rr_arb2
  import bus_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [1:0] req_i,
  input  logic       gnt_en_i,
  output logic [1:0] gnt_c_o,
  output logic       last_q_o
);

  logic last_q;
  logic last_d;

  // A lone requester always wins; on contention the port not granted last wins.
  always_comb begin
    gnt_c_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = last_q ? 2'b01 : 2'b10;
      default: gnt_c_o = 2'b00;
    endcase
  end

  // Pointer follows each committed grant.
  always_comb begin
    last_d = last_q;
    if (gnt_en_i && (|req_i)) begin
      last_d = gnt_c_o[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_q_o = last_q;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences transfers on the shared address/data bus between Memory and Reg.
//   CLK, RSTn              : clock and synchronous active-low reset
//   req0/1, we0/1          : requests and write flags from requesters 0/1
//   addr0/1, wdata0/1      : transfer address and write data
//   done0/1                : one-cycle completion pulse to the granted requester
//   rdata                  : read data, captured at the last ACCESS edge
//   busy                   : high outside IDLE
//   ADDR, DOUT, DOUT_EN    : address bus, write data and tri-state enable
//   DIN                    : data bus value sampled on reads
//   M_ON/M_W, R_ON/R_W     : Memory and Reg enable/write strobes
// All outputs are registered; the next-state logic computes each output's
// value for the state being entered.
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SEL_BIT     = 15
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_EN,
  input  logic [DW-1:0] DIN,
  output logic          M_ON,
  output logic          M_W,
  output logic          R_ON,
  output logic          R_W
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             tgt_q, tgt_d;

  logic [1:0]       gnt;
  logic             gnt_en;
  logic             last_gnt;

  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  logic             done0_d, done1_d, busy_d, dout_en_d;
  logic             m_on_d, m_w_d, r_on_d, r_w_d;
  logic [DW-1:0]    rdata_d, dout_d;
  logic [AW-1:0]    addr_d;

  rr_arb2 u_arb (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .req_i    ({req1, req0}),
    .gnt_en_i (gnt_en),
    .gnt_c_o  (gnt),
    .last_q_o (last_gnt)
  );

  // Winner's request fields.
  assign sel_we    = gnt[1] ? we1    : we0;
  assign sel_addr  = gnt[1] ? addr1  : addr0;
  assign sel_wdata = gnt[1] ? wdata1 : wdata0;

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    tgt_d   = tgt_q;
    addr_d  = ADDR;
    dout_d  = DOUT;
    rdata_d = rdata;
    gnt_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          gnt_en  = 1'b1;
          we_d    = sel_we;
          tgt_d   = sel_addr[SEL_BIT];
          addr_d  = sel_addr;
          if (sel_we) begin
            dout_d = sel_wdata;
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_W'(WAIT_CYCLES);
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = DIN;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    // Write data is driven from SETUP through the last ACCESS cycle; DONE turns the bus around.
    dout_en_d = we_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS));
    m_on_d    = (state_d == ST_ACCESS) && (tgt_d == TGT_MEM);
    r_on_d    = (state_d == ST_ACCESS) && (tgt_d == TGT_REG);
    m_w_d     = m_on_d && we_d;
    r_w_d     = r_on_d && we_d;
    // The pointer only moves on grants, so mid-transfer it names the granted port.
    done0_d   = (state_d == ST_DONE) && !last_gnt;
    done1_d   = (state_d == ST_DONE) && last_gnt;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      tgt_q   <= TGT_MEM;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      ADDR    <= '0;
      DOUT    <= '0;
      DOUT_EN <= 1'b0;
      M_ON    <= 1'b0;
      M_W     <= 1'b0;
      R_ON    <= 1'b0;
      R_W     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      tgt_q   <= tgt_d;
      done0   <= done0_d;
      done1   <= done1_d;
      rdata   <= rdata_d;
      busy    <= busy_d;
      ADDR    <= addr_d;
      DOUT    <= dout_d;
      DOUT_EN <= dout_en_d;
      M_ON    <= m_on_d;
      M_W     <= m_w_d;
      R_ON    <= r_on_d;
      R_W     <= r_w_d;
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: three instances (WAIT_CYCLES = 1, 0, 3)
// each driven by random requesters and random resets, compared every cycle
// against a transfer-phase reference model.
module tb_bus_xfer_ctrl;

  localparam int NCYC = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    logic        rst_n, req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1, din;
    logic        done0, done1, busy, dout_en, m_on, m_w, r_on, r_w;
    logic [15:0] rdata, addr_bus, dout;
    logic        fin = 1'b0;

    bus_xfer_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .CLK     (clk),
      .RSTn    (rst_n),
      .req0    (req0),
      .req1    (req1),
      .we0     (we0),
      .we1     (we1),
      .addr0   (addr0),
      .addr1   (addr1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .done0   (done0),
      .done1   (done1),
      .rdata   (rdata),
      .busy    (busy),
      .ADDR    (addr_bus),
      .DOUT    (dout),
      .DOUT_EN (dout_en),
      .DIN     (din),
      .M_ON    (m_on),
      .M_W     (m_w),
      .R_ON    (r_on),
      .R_W     (r_w)
    );

    initial begin : run
      // Model: ph = cycles since the grant was sampled (1 = SETUP), -1 when idle.
      int          ph;
      logic        m_last, m_port, m_we, m_tgt, just_rst;
      logic [15:0] m_addr, m_wdata, m_rdata;
      logic        e_busy, e_on, e_en, e_done;
      string       pfx;

      pfx = $sformatf("w%0d.", W);
      ph = -1; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0; m_tgt = 1'b0; just_rst = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; din = '0;

      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #1;
        // Advance the model using the inputs present at this edge.
        if (!rst_n) begin
          ph = -1; m_last = 1'b1; m_rdata = '0; just_rst = 1'b1;
        end else begin
          just_rst = 1'b0;
          if (ph < 0) begin
            if (req0 || req1) begin
              m_port  = (req0 && req1) ? ~m_last : req1;
              m_last  = m_port;
              m_we    = m_port ? we1 : we0;
              m_addr  = m_port ? addr1 : addr0;
              m_wdata = m_port ? wdata1 : wdata0;
              m_tgt   = m_addr[15];
              ph      = 1;
            end
          end else begin
            if (ph == 2 + W && !m_we) m_rdata = din;
            ph = (ph == 3 + W) ? -1 : ph + 1;
          end
        end

        e_busy = (ph >= 1);
        e_on   = (ph >= 2) && (ph <= 2 + W);
        e_en   = m_we && (ph >= 1) && (ph <= 2 + W);
        e_done = (ph == 3 + W);

        if (just_rst) begin
          check({pfx, "rst_ctrl"},
                32'({busy, done0, done1, dout_en, m_on, m_w, r_on, r_w}), 32'(0));
          check({pfx, "rst_bus"}, {addr_bus, dout}, 32'(0));
          check({pfx, "rst_rdata"}, 32'(rdata), 32'(0));
        end else begin
          check({pfx, "busy"}, 32'(busy), 32'(e_busy));
          check({pfx, "done0"}, 32'(done0), 32'(e_done && !m_port));
          check({pfx, "done1"}, 32'(done1), 32'(e_done && m_port));
          check({pfx, "M_ON"}, 32'(m_on), 32'(e_on && !m_tgt));
          check({pfx, "M_W"}, 32'(m_w), 32'(e_on && !m_tgt && m_we));
          check({pfx, "R_ON"}, 32'(r_on), 32'(e_on && m_tgt));
          check({pfx, "R_W"}, 32'(r_w), 32'(e_on && m_tgt && m_we));
          check({pfx, "DOUT_EN"}, 32'(dout_en), 32'(e_en));
          check({pfx, "rdata"}, 32'(rdata), 32'(m_rdata));
          if (e_busy) check({pfx, "ADDR"}, 32'(addr_bus), 32'(m_addr));
          if (e_en) check({pfx, "DOUT"}, 32'(dout), 32'(m_wdata));
        end

        // Drive inputs for the next edge.
        din = 16'($urandom);
        if (c < 2) begin
          rst_n = 1'b0;
        end else if (c < 30) begin
          rst_n = 1'b1;
        end else begin
          rst_n = ($urandom_range(0, 79) != 0);
        end

        if (c == 2) begin
          // Directed contention straight out of reset.
          req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0000;
          req1 = 1'b1; we1 = 1'b1; addr1 = 16'h8003; wdata1 = 16'h1234;
        end else if (c >= 30) begin
          if (!req0) begin
            if ($urandom_range(0, 2) == 0) begin
              req0 = 1'b1; we0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = 16'($urandom);
            end
          end else if (done0) begin
            req0 = 1'($urandom);
            we0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = 16'($urandom);
          end
          if (!req1) begin
            if ($urandom_range(0, 2) == 0) begin
              req1 = 1'b1; we1 = 1'($urandom); addr1 = 16'($urandom); wdata1 = 16'($urandom);
            end
          end else if (done1) begin
            req1 = 1'($urandom);
            we1 = 1'($urandom); addr1 = 16'($urandom); wdata1 = 16'($urandom);
          end
        end
      end
      fin = 1'b1;
    end
  end

  initial begin : summary
    int t;
    t = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && t < NCYC + 100) begin
      @(posedge clk);
      t++;
    end
    check("finish", 32'({g_inst[2].fin, g_inst[1].fin, g_inst[0].fin}), 32'(3'b111));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
